// File: rtl/base_rr_sched.sv
// Round-robin scheduler that shares one downstream port among `ways` requesters.
// Holds each grant across a multi-beat burst and rotates priority on the last beat.
module base_rr_sched #(
    parameter int ways      = 4,
    parameter int enc_width = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [0:ways-1]      i_req,
    input  logic [0:ways-1]      i_last,
    input  logic                 i_r,
    output logic                 o_v,
    output logic [0:ways-1]      o_gnt,
    output logic [0:enc_width-1] o_gnt_enc,
    output logic [0:ways-1]      o_ack
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state;
    logic [enc_width-1:0] ptr;

    logic [enc_width-1:0] arb_ptr;
    logic [0:ways-1]      arb_req;
    logic                 win_found;
    logic [enc_width-1:0] win_idx;
    logic [0:ways-1]      win_oh;

    logic                 beat;
    logic                 release_beat;

    assign beat         = o_v & i_r;
    assign release_beat = beat & (|(i_last & o_gnt));
    assign o_ack        = o_gnt & {ways{beat}};

    // At release the holder's index becomes the new pointer in the same cycle,
    // and the holder is masked so it can only win again through IDLE.
    always_comb begin
        if (state == GRANT) begin
            arb_ptr = o_gnt_enc;
            arb_req = i_req & ~o_gnt;
        end else begin
            arb_ptr = ptr;
            arb_req = i_req;
        end
    end

    // First requester above the pointer wins; otherwise wrap to the lowest one.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        for (int j = 0; j < ways; j++) begin
            if (!win_found && arb_req[j] && (j > int'(arb_ptr))) begin
                win_found = 1'b1;
                win_idx   = enc_width'(j);
                win_oh[j] = 1'b1;
            end
        end
        for (int j = 0; j < ways; j++) begin
            if (!win_found && arb_req[j] && (j <= int'(arb_ptr))) begin
                win_found = 1'b1;
                win_idx   = enc_width'(j);
                win_oh[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            o_v       <= 1'b0;
            o_gnt     <= '0;
            o_gnt_enc <= '0;
            ptr       <= enc_width'(ways - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        o_v       <= 1'b1;
                        o_gnt     <= win_oh;
                        o_gnt_enc <= win_idx;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_beat) begin
                        ptr <= o_gnt_enc;
                        if (win_found) begin
                            o_gnt     <= win_oh;
                            o_gnt_enc <= win_idx;
                        end else begin
                            o_v       <= 1'b0;
                            o_gnt     <= '0;
                            o_gnt_enc <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_base_rr_sched.sv
// Scoreboard bench for base_rr_sched: expected outputs are queued as each
// cycle's stimulus is driven and compared once the outputs have settled.
module tb_base_rr_sched;

    typedef struct packed {
        logic       v;
        logic [0:3] gnt;
        logic [0:1] enc;
        logic [0:3] ack;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [0:3] i_req;
    logic [0:3] i_last;
    logic       i_r;
    logic       o_v;
    logic [0:3] o_gnt;
    logic [0:1] o_gnt_enc;
    logic [0:3] o_ack;

    exp_t exp_q[$];
    exp_t got;
    exp_t want;
    int   n_checks;
    int   n_fail;

    base_rr_sched #(
        .ways     (4),
        .enc_width(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_last   (i_last),
        .i_r      (i_r),
        .o_v      (o_v),
        .o_gnt    (o_gnt),
        .o_gnt_enc(o_gnt_enc),
        .o_ack    (o_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic v, input logic [0:3] g, input logic [0:1] e,
                                input logic [0:3] a);
        mk = {v, g, e, a};
    endfunction

    task automatic apply_stimulus(input logic [0:3] req, input logic [0:3] last, input logic r);
        i_req  = req;
        i_last = last;
        i_r    = r;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply_stimulus(4'b0000, 4'b0000, 1'b1);
        exp_q.push_back(mk(1'b0, 4'b0000, 2'd0, 4'b0000));
        #1;
        got  = {o_v, o_gnt, o_gnt_enc, o_ack};
        want = exp_q.pop_front();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("[TB] FAIL reset_asserted: got %b expected %b", got, want);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(4'b0000, 4'b0000, 1'b1);
            exp_q.push_back(mk(1'b0, 4'b0000, 2'd0, 4'b0000));
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL reset_idle[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rotation();
        exp_t e_t[7];
        e_t = '{mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b1000, 2'd0, 4'b1000),
                mk(1'b1, 4'b0100, 2'd1, 4'b0100), mk(1'b1, 4'b0010, 2'd2, 4'b0010),
                mk(1'b1, 4'b0001, 2'd3, 4'b0001), mk(1'b1, 4'b1000, 2'd0, 4'b1000),
                mk(1'b1, 4'b0100, 2'd1, 4'b0100)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            apply_stimulus(4'b1111, 4'b1111, 1'b1);
            exp_q.push_back(e_t[c]);
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL rotation[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_burst();
        logic [0:3] req_t[6];
        logic [0:3] last_t[6];
        exp_t       e_t[6];
        req_t  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011};
        last_t = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        e_t    = '{mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0010, 2'd2, 4'b0010),
                   mk(1'b1, 4'b0010, 2'd2, 4'b0010), mk(1'b1, 4'b0010, 2'd2, 4'b0010),
                   mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0001, 2'd3, 4'b0001)};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(req_t[c], last_t[c], 1'b1);
            exp_q.push_back(e_t[c]);
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL burst[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_waiting();
        logic [0:3] req_t[7];
        logic [0:3] last_t[7];
        exp_t       e_t[7];
        req_t  = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        last_t = '{4'b0000, 4'b1001, 4'b0000, 4'b0010, 4'b0001, 4'b1000, 4'b0000};
        e_t    = '{mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0010, 2'd2, 4'b0010),
                   mk(1'b1, 4'b0010, 2'd2, 4'b0010), mk(1'b1, 4'b0010, 2'd2, 4'b0010),
                   mk(1'b1, 4'b0001, 2'd3, 4'b0001), mk(1'b1, 4'b1000, 2'd0, 4'b1000),
                   mk(1'b0, 4'b0000, 2'd0, 4'b0000)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            apply_stimulus(req_t[c], last_t[c], 1'b1);
            exp_q.push_back(e_t[c]);
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL waiting[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall();
        logic [0:3] req_t[8];
        logic [0:3] last_t[8];
        logic       r_t[8];
        exp_t       e_t[8];
        req_t  = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        last_t = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        r_t    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        e_t    = '{mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0100, 2'd1, 4'b0000),
                   mk(1'b1, 4'b0100, 2'd1, 4'b0000), mk(1'b1, 4'b0100, 2'd1, 4'b0000),
                   mk(1'b1, 4'b0100, 2'd1, 4'b0000), mk(1'b1, 4'b0100, 2'd1, 4'b0100),
                   mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0100, 2'd1, 4'b0100)};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            apply_stimulus(req_t[c], last_t[c], r_t[c]);
            exp_q.push_back(e_t[c]);
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL stall[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e_t[5];
        e_t = '{mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b1, 4'b0001, 2'd3, 4'b0001),
                mk(1'b0, 4'b0000, 2'd0, 4'b0000), mk(1'b0, 4'b0000, 2'd0, 4'b0000),
                mk(1'b1, 4'b1000, 2'd0, 4'b1000)};
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                reset = 1'b1;
            end else if (c == 3) begin
                reset = 1'b0;
            end
            apply_stimulus((c < 2) ? 4'b0001 : 4'b1001, 4'b0000, 1'b1);
            exp_q.push_back(e_t[c]);
            #1;
            got  = {o_v, o_gnt, o_gnt_enc, o_ack};
            want = exp_q.pop_front();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL reset_mid[%0d]: got %b expected %b", c, got, want);
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_rotation();
        test_burst();
        test_waiting();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/base_rr_sched.md
Name: base_rr_sched

Overview:
- Round-robin scheduler that shares one downstream datapath/port among `ways` requesters.
- Selects one requester, holds the grant across a multi-beat transfer until the last beat is accepted, then rotates priority.
- Presents the winner both one-hot and binary-encoded, so the binary index can drive a shared mux select.
- Sits in front of a `base_mux`-style datapath select. Downstream handshake is valid/ready.

Parameters:
- ways, 4, number of requesters (>=2).
- enc_width, 2, width of encoded grant index; must satisfy 2^enc_width >= ways.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  [0:ways-1]  per-requester request; requester holds it until its last beat is accepted.
- i_last  input  [0:ways-1]  per-requester last-beat flag; only the granted requester's bit is sampled.
- i_r  input  1  downstream ready.
- o_v  output  1  grant active / beat valid to downstream.
- o_gnt  output  [0:ways-1]  registered one-hot grant.
- o_gnt_enc  output  [0:enc_width-1]  binary index of o_gnt; bit 0 is MSB.
- o_ack  output  [0:ways-1]  combinational per-requester beat accept: o_gnt & {ways{o_v & i_r}}.

Behaviour:
- Reset values (asynchronous, immediate):
  - o_v=0, o_gnt=0, o_gnt_enc=0, o_ack=0, state=IDLE.
  - Last-winner pointer ptr = ways-1, so requester 0 has first priority.
- Arbitration function:
  - Scans requesters ptr+1, ptr+2, … wrapping modulo ways; the first with i_req=1 wins.
  - Exactly one winner; no winner if i_req=0.
  - Wrap: ptr=ways-1 scans from 0.
- IDLE state:
  - If |i_req, register the winner into o_gnt/o_gnt_enc, set o_v=1, go to GRANT.
  - Grant is visible on the cycle after the request (1-cycle latency).
  - If no request, stay in IDLE with outputs at 0.
- GRANT state:
  - Grant is frozen; changes on i_req, including deassertion by the holder (protocol violation), are ignored.
  - A beat transfers when o_v & i_r.
  - Transfer without i_last[granted]: remain in GRANT.
  - Transfer with i_last[granted] (release):
    - ptr <= granted index.
    - Re-arbitrate the same cycle using the updated ptr over current i_req, with the releasing requester's bit masked out.
    - Winner present: o_gnt/o_gnt_enc load the new winner, o_v stays 1 (back-to-back, zero bubble).
    - No other request: o_v=0, o_gnt=0, o_gnt_enc=0, go to IDLE.
    - The releasing requester may win again only via IDLE on a later cycle.
  - o_v=1 and i_r=0: hold all outputs; no change.
- Simultaneous events:
  - New requests arriving during GRANT wait; they are considered at release.
  - A requester that asserts i_req and i_last on its first granted beat gets a single-beat transfer.
- o_gnt_enc always equals the encoding of o_gnt; it is 0 when o_gnt=0. o_v implies o_gnt is one-hot.
- Reset mid-transfer: all outputs drop in the same cycle, and ptr returns to ways-1.
- No combinational path from i_req to any output. o_ack depends combinationally on i_r only.

Test Plan:
- Reset, i_req=0000 for 5 cycles -> o_v=0, o_gnt=0000, o_gnt_enc=00, o_ack=0000 throughout.
- i_req=1111 held, i_r=1, every beat i_last=1 -> o_gnt sequence 1000,0100,0010,0001,1000… with o_gnt_enc 0,1,2,3,0. o_v stays 1 with no bubble, since each releasing requester's bit is masked at its release.
- i_req=0010, 3-beat burst with i_last on beat 3, i_r=1 -> o_gnt=0010, o_gnt_enc=2 for 3 cycles. o_ack[2] pulses 3 times. Then o_v=0 and ptr=2.
- During the Scenario-3 burst, assert i_req[0] and i_req[3] at beat 1 -> grant stays 0010 until last. Next grant is 0001 (enc 3, after ptr=2), then 1000.
- Granted requester 1, i_r=0 for 4 cycles with i_last=1 -> o_v=1, o_gnt=0100, o_ack=0000 held. Release occurs only on the cycle i_r=1.
- Assert reset mid-burst (o_gnt=0001) -> outputs 0 immediately. After deassert with i_req=1001, next grant is 1000 (ptr reset to ways-1).
